// File: rtl/image_histogram_pkg.sv
// Shared definitions for the image_histogram block.
//   hist_state_e  : controller state encoding (also exported for debug)
//   NUM_BINS      : number of intensity bins (one per 8-bit grey level)
//   BIN_AW        : bin address width
//   DEF_PIX_LIMIT : pixels per frame for the default 768 x 512 geometry
//   pix_limit()   : pixels per frame for any WIDTH x HEIGHT
package image_histogram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } hist_state_e;

    localparam int NUM_BINS      = 256;
    localparam int BIN_AW        = 8;
    localparam int DEF_WIDTH     = 768;
    localparam int DEF_HEIGHT    = 512;
    localparam int DEF_PIX_LIMIT = DEF_WIDTH * DEF_HEIGHT;

    function automatic int pix_limit(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/image_histogram_hist_bin_ram.sv
// 256 x CNT_W histogram bin storage (hist_bin_ram).
//   HCLK, HRESET         : clock, synchronous active-high reset (read port only)
//   clr_en, clr_addr     : write zero to one bin
//   inc_en, inc_addr0/1  : add one to each addressed bin; equal addresses add two
//   rd_en, rd_addr       : registered read request
//   rd_data              : bin value one cycle after rd_en, zero otherwise
// Bin contents are not reset; the controller clears them before each frame.
module image_histogram_hist_bin_ram
    import image_histogram_pkg::*;
#(
    parameter int CNT_W = 19
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              clr_en,
    input  logic [BIN_AW-1:0] clr_addr,
    input  logic              inc_en,
    input  logic [BIN_AW-1:0] inc_addr0,
    input  logic [BIN_AW-1:0] inc_addr1,
    input  logic              rd_en,
    input  logic [BIN_AW-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data
);

    logic [CNT_W-1:0] mem [NUM_BINS];

    // Saturating add of a 1- or 2-count step.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       step);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, step};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Each bin decides its own update, so two hits on the same bin merge
    // into a single +2 instead of one write overwriting the other.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < NUM_BINS; i++) begin
            if (clr_en && (clr_addr == BIN_AW'(i))) begin
                mem[i] <= '0;
            end else if (inc_en && ((inc_addr0 == BIN_AW'(i)) || (inc_addr1 == BIN_AW'(i)))) begin
                mem[i] <= sat_add(mem[i], {(inc_addr0 == BIN_AW'(i)) && (inc_addr1 == BIN_AW'(i)),
                                           (inc_addr0 == BIN_AW'(i)) ^  (inc_addr1 == BIN_AW'(i))});
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/image_histogram.sv
// 256-bin intensity histogram of a two-pixel-per-clock grey stream.
//   HCLK, HRESET          : clock, synchronous active-high reset
//   VSYNC                 : rising edge starts a new frame (clear, then accumulate)
//   HSYNC, PIX0, PIX1     : pixel pair valid / even pixel / odd pixel
//   rd_en, rd_addr        : bin readout request (served only while frozen)
//   rd_data, rd_valid     : bin count one cycle after rd_en
//   hist_ready            : histogram complete and frozen
//   frame_done            : one-cycle pulse when the last pair is counted
//   frame_err             : sticky; pair during clear or early VSYNC
//   fsm_state             : controller state, for debug
module image_histogram
    import image_histogram_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int CNT_W  = 19
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic [7:0]        PIX0,
    input  logic [7:0]        PIX1,
    input  logic              rd_en,
    input  logic [7:0]        rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              hist_ready,
    output logic              frame_done,
    output logic              frame_err,
    output hist_state_e       fsm_state
);

    localparam logic [CNT_W-1:0] PIX_LIMIT = CNT_W'(pix_limit(WIDTH, HEIGHT));

    hist_state_e       state, state_nxt;
    logic              vsync_d;
    logic              vsync_rise;
    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  pix_cnt_inc;
    logic [BIN_AW-1:0] clr_ptr;

    logic start_clear;     // entering (or restarting) the clear phase
    logic clr_en;
    logic inc_en;
    logic err_set;
    logic err_clr;
    logic frame_complete;
    logic rd_serve;

    assign vsync_rise  = VSYNC & ~vsync_d;
    assign pix_cnt_inc = pix_cnt + CNT_W'(2);
    assign fsm_state   = state;
    // A read in the VSYNC-rise cycle still sees frozen bins: the clear
    // writes only begin once the state has moved to ST_CLEAR.
    assign rd_serve    = rd_en && (state == ST_DONE);

    always_comb begin
        state_nxt      = state;
        start_clear    = 1'b0;
        clr_en         = 1'b0;
        inc_en         = 1'b0;
        err_set        = 1'b0;
        err_clr        = 1'b0;
        frame_complete = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vsync_rise) begin
                    state_nxt   = ST_CLEAR;
                    start_clear = 1'b1;
                    err_clr     = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (HSYNC) begin
                    err_set = 1'b1;
                end
                if (vsync_rise) begin
                    start_clear = 1'b1;
                end else if (clr_ptr == BIN_AW'(NUM_BINS - 1)) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // An early VSYNC abandons the partial frame; its pair is
                // not counted since the bins are about to be cleared.
                if (vsync_rise) begin
                    state_nxt   = ST_CLEAR;
                    start_clear = 1'b1;
                    err_set     = 1'b1;
                end else if (HSYNC) begin
                    inc_en = 1'b1;
                    if (pix_cnt_inc == PIX_LIMIT) begin
                        state_nxt      = ST_DONE;
                        frame_complete = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (vsync_rise) begin
                    state_nxt   = ST_CLEAR;
                    start_clear = 1'b1;
                    err_clr     = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            vsync_d    <= 1'b0;
            pix_cnt    <= '0;
            clr_ptr    <= '0;
            rd_valid   <= 1'b0;
            hist_ready <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            vsync_d    <= VSYNC;
            rd_valid   <= rd_serve;
            frame_done <= frame_complete;

            if (start_clear) begin
                clr_ptr <= '0;
            end else if (clr_en) begin
                clr_ptr <= clr_ptr + BIN_AW'(1);
            end

            if (start_clear) begin
                pix_cnt <= '0;
            end else if (inc_en) begin
                pix_cnt <= pix_cnt_inc;
            end

            if (frame_complete) begin
                hist_ready <= 1'b1;
            end else if (start_clear) begin
                hist_ready <= 1'b0;
            end

            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    image_histogram_hist_bin_ram #(
        .CNT_W (CNT_W)
    ) u_hist_bin_ram (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .clr_en    (clr_en),
        .clr_addr  (clr_ptr),
        .inc_en    (inc_en),
        .inc_addr0 (PIX0),
        .inc_addr1 (PIX1),
        .rd_en     (rd_serve),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_image_histogram.sv
module tb_image_histogram;
    import image_histogram_pkg::*;

    localparam int CNT_W = 19;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             VSYNC;
    logic             HSYNC;
    logic [7:0]       PIX0;
    logic [7:0]       PIX1;
    logic             rd_en;
    logic [7:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic             hist_ready;
    logic             frame_done;
    logic             frame_err;
    hist_state_e      fsm_state;

    int vec_cnt  = 0;
    int mis_cnt  = 0;
    int fd_count = 0;
    int unsigned model [256];

    typedef struct {
        logic [7:0]       addr;
        logic [CNT_W-1:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tbl [7];

    image_histogram #(
        .WIDTH  (4),
        .HEIGHT (2),
        .CNT_W  (CNT_W)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .VSYNC      (VSYNC),
        .HSYNC      (HSYNC),
        .PIX0       (PIX0),
        .PIX1       (PIX1),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .hist_ready (hist_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .fsm_state  (fsm_state)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit counted);
        HSYNC = 1'b1;
        PIX0  = a;
        PIX1  = b;
        step();
        HSYNC = 1'b0;
        if (counted) begin
            model[a] = model[a] + 1;
            model[b] = model[b] + 1;
        end
    endtask

    // VSYNC pulse, then enough idle cycles for the 256-cycle clear.
    task automatic start_frame();
        VSYNC = 1'b1;
        step();
        VSYNC = 1'b0;
        model_clear();
        repeat (259) step();
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 256; i++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(i);
            step();
            check($sformatf("%s_rdv[%0d]", tag, i), 32'(rd_valid), 32'd1);
            check($sformatf("%s_bin[%0d]", tag, i), 32'(rd_data), model[i]);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        HRESET  = 1'b1;
        VSYNC   = 1'b0;
        HSYNC   = 1'b0;
        PIX0    = '0;
        PIX1    = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        model_clear();

        rd_tbl[0] = '{8'd10,  19'd3};
        rd_tbl[1] = '{8'd20,  19'd2};
        rd_tbl[2] = '{8'd30,  19'd1};
        rd_tbl[3] = '{8'd40,  19'd2};
        rd_tbl[4] = '{8'd0,   19'd0};
        rd_tbl[5] = '{8'd255, 19'd0};
        rd_tbl[6] = '{8'd11,  19'd0};

        // ---- reset state
        step();
        step();
        HRESET = 1'b0;
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_hist_ready", 32'(hist_ready), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // ---- basic frame
        start_frame();
        check("f1_state_accum", 32'(fsm_state), 32'(ST_ACCUM));
        rd_en   = 1'b1;
        rd_addr = 8'd10;
        step();
        rd_en = 1'b0;
        check("accum_rd_valid", 32'(rd_valid), 32'd0);
        check("accum_rd_data", 32'(rd_data), 32'd0);
        send_pair(8'd10, 8'd20, 1'b1);
        send_pair(8'd10, 8'd30, 1'b1);
        send_pair(8'd40, 8'd40, 1'b1);
        check("f1_no_done_early", 32'(fd_count), 32'd0);
        send_pair(8'd10, 8'd20, 1'b1);
        check("f1_frame_done", 32'(frame_done), 32'd1);
        check("f1_hist_ready", 32'(hist_ready), 32'd1);
        check("f1_state_done", 32'(fsm_state), 32'(ST_DONE));
        step();
        check("f1_done_pulse", 32'(frame_done), 32'd0);
        check("f1_ready_hold", 32'(hist_ready), 32'd1);
        check("f1_err", 32'(frame_err), 32'd0);

        // back-to-back reads from the hand-computed table
        for (int i = 0; i < 7; i++) begin
            rd_en   = 1'b1;
            rd_addr = rd_tbl[i].addr;
            step();
            check($sformatf("tbl_rdv[%0d]", i), 32'(rd_valid), 32'd1);
            check($sformatf("tbl_bin[%0d]", i), 32'(rd_data), 32'(rd_tbl[i].exp));
        end
        rd_en = 1'b0;
        step();
        check("rd_idle_valid", 32'(rd_valid), 32'd0);
        check("rd_idle_data", 32'(rd_data), 32'd0);

        // pairs while frozen are ignored
        send_pair(8'd10, 8'd10, 1'b0);
        sweep("f1");

        // ---- same-bin pairs, with a read in the VSYNC-rise cycle
        rd_en   = 1'b1;
        rd_addr = 8'd10;
        VSYNC   = 1'b1;
        step();
        VSYNC = 1'b0;
        rd_en = 1'b0;
        check("vs_rd_valid", 32'(rd_valid), 32'd1);
        check("vs_rd_data", 32'(rd_data), 32'd3);
        check("vs_state", 32'(fsm_state), 32'(ST_CLEAR));
        check("vs_hist_ready", 32'(hist_ready), 32'd0);
        model_clear();
        repeat (259) step();
        for (int i = 0; i < 4; i++) send_pair(8'd255, 8'd255, 1'b1);
        check("f2_frame_done", 32'(frame_done), 32'd1);
        check("f2_bin255_model", model[255], 32'd8);
        sweep("f2");

        // ---- early VSYNC after 2 of 4 pairs
        start_frame();
        send_pair(8'd1, 8'd2, 1'b0);
        send_pair(8'd3, 8'd4, 1'b0);
        fd_count = 0;
        VSYNC = 1'b1;
        step();
        VSYNC = 1'b0;
        check("early_err", 32'(frame_err), 32'd1);
        check("early_state", 32'(fsm_state), 32'(ST_CLEAR));
        model_clear();
        repeat (259) step();
        check("early_no_done", 32'(fd_count), 32'd0);
        send_pair(8'd5, 8'd6, 1'b1);
        send_pair(8'd5, 8'd7, 1'b1);
        send_pair(8'd128, 8'd0, 1'b1);
        send_pair(8'd6, 8'd6, 1'b1);
        check("f3_frame_done", 32'(frame_done), 32'd1);
        check("f3_err_sticky", 32'(frame_err), 32'd1);
        sweep("f3");
        VSYNC = 1'b1;
        step();
        VSYNC = 1'b0;
        check("f4_err_cleared", 32'(frame_err), 32'd0);

        // ---- HSYNC inside the clear phase (100 cycles after the rise)
        model_clear();
        repeat (99) step();
        check("clr_state", 32'(fsm_state), 32'(ST_CLEAR));
        send_pair(8'd9, 8'd9, 1'b0);
        check("clr_hsync_err", 32'(frame_err), 32'd1);
        repeat (200) step();
        send_pair(8'd100, 8'd101, 1'b1);
        send_pair(8'd102, 8'd103, 1'b1);
        send_pair(8'd104, 8'd105, 1'b1);
        check("f4_no_done_3", 32'(frame_done), 32'd0);
        send_pair(8'd106, 8'd107, 1'b1);
        check("f4_frame_done", 32'(frame_done), 32'd1);
        sweep("f4");

        // ---- reset mid-accumulation
        start_frame();
        send_pair(8'd50, 8'd51, 1'b0);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_ready", 32'(hist_ready), 32'd0);
        check("mid_rst_done", 32'(frame_done), 32'd0);
        check("mid_rst_err", 32'(frame_err), 32'd0);
        fd_count = 0;
        for (int i = 0; i < 6; i++) send_pair(8'(i), 8'(i + 1), 1'b0);
        step();
        check("novs_ready", 32'(hist_ready), 32'd0);
        check("novs_done_cnt", 32'(fd_count), 32'd0);
        check("novs_state", 32'(fsm_state), 32'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
